// File: rtl/writeback_unit.sv
// writeback_unit
//   Final RV32I pipeline stage. Takes one retiring instruction at a time from
//   execute, issues the data-memory read for loads (with a response timeout),
//   aligns and extends load data, and pulses a single register-file write.
//
//   Ports
//     clk, rst            clock; asynchronous active-low reset
//     ex_*                instruction from execute (valid/ready handshake)
//     dmem_req_o/addr_o   one-cycle word-aligned read request
//     dmem_rvalid_i/rdata_i  read response
//     rd_o/datawb_o/regwren_o  register-file write port
//     pending_o/pending_rd_o   held-instruction visibility for hazard logic
//     err_o               sticky: illegal/misaligned load or response timeout
//
//   state    | meaning
//   IDLE     | empty, ready to accept
//   REQ      | load request on the bus this cycle
//   WAIT_MEM | waiting for read data, timeout counter running
//   WRITE    | one-cycle register write slot, can accept the next instruction
module writeback_unit #(
   parameter int DWIDTH  = 32,
   parameter int AWIDTH  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid_i,
   output logic              ex_ready_o,
   input  logic [4:0]        ex_rd_i,
   input  logic              ex_regwren_i,
   input  logic [1:0]        ex_wbsel_i,
   input  logic [DWIDTH-1:0] ex_alu_i,
   input  logic [AWIDTH-1:0] ex_pc_i,
   input  logic [2:0]        ex_funct3_i,
   output logic              dmem_req_o,
   output logic [AWIDTH-1:0] dmem_addr_o,
   input  logic              dmem_rvalid_i,
   input  logic [DWIDTH-1:0] dmem_rdata_i,
   output logic [4:0]        rd_o,
   output logic [DWIDTH-1:0] datawb_o,
   output logic              regwren_o,
   output logic              pending_o,
   output logic [4:0]        pending_rd_o,
   output logic              err_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_REQ      = 2'd1,
      S_WAIT_MEM = 2'd2,
      S_WRITE    = 2'd3
   } state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [4:0]        lat_rd;
   logic              lat_regwren;
   logic [2:0]        lat_funct3;
   logic [1:0]        lat_lane;

   logic              accept;
   logic              is_load;
   logic              load_ok;
   logic [AWIDTH-1:0] pc_plus4;
   logic [DWIDTH-1:0] nonload_data;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [DWIDTH-1:0] ld_data;

   assign ex_ready_o   = (state == S_IDLE) || (state == S_WRITE);
   assign dmem_req_o   = (state == S_REQ);
   assign pending_o    = (state != S_IDLE);
   assign pending_rd_o = (pending_o && lat_regwren) ? lat_rd : 5'd0;

   assign accept   = ex_valid_i && ex_ready_o;
   assign is_load  = (ex_wbsel_i == 2'd1);
   assign pc_plus4 = ex_pc_i + AWIDTH'(4);
   // wbsel 3 is reserved and falls back to the ALU result
   assign nonload_data = (ex_wbsel_i == 2'd2) ? DWIDTH'(pc_plus4) : ex_alu_i;

   always_comb begin
      load_ok = 1'b0;
      case (ex_funct3_i)
         3'b000, 3'b100: load_ok = 1'b1;
         3'b001, 3'b101: load_ok = ~ex_alu_i[0];
         3'b010:         load_ok = (ex_alu_i[1:0] == 2'b00);
         default:        load_ok = 1'b0;
      endcase
   end

   always_comb begin
      ld_byte = dmem_rdata_i[{lat_lane, 3'b000} +: 8];
      ld_half = dmem_rdata_i[{lat_lane[1], 4'b0000} +: 16];
      case (lat_funct3)
         3'b000:  ld_data = {{(DWIDTH-8){ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {{(DWIDTH-8){1'b0}}, ld_byte};
         3'b001:  ld_data = {{(DWIDTH-16){ld_half[15]}}, ld_half};
         3'b101:  ld_data = {{(DWIDTH-16){1'b0}}, ld_half};
         default: ld_data = dmem_rdata_i;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         lat_rd      <= '0;
         lat_regwren <= 1'b0;
         lat_funct3  <= '0;
         lat_lane    <= '0;
         dmem_addr_o <= '0;
         rd_o        <= '0;
         datawb_o    <= '0;
         regwren_o   <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         regwren_o <= 1'b0;
         case (state)
            S_IDLE, S_WRITE: begin
               if (accept) begin
                  lat_rd      <= ex_rd_i;
                  lat_regwren <= ex_regwren_i;
                  lat_funct3  <= ex_funct3_i;
                  lat_lane    <= ex_alu_i[1:0];
                  if (is_load && load_ok) begin
                     state       <= S_REQ;
                     dmem_addr_o <= {ex_alu_i[AWIDTH-1:2], 2'b00};
                  end else if (is_load) begin
                     // bad load still occupies a write slot, but never writes
                     state <= S_WRITE;
                     err_o <= 1'b1;
                  end else begin
                     state     <= S_WRITE;
                     rd_o      <= ex_rd_i;
                     datawb_o  <= nonload_data;
                     regwren_o <= ex_regwren_i && (ex_rd_i != 5'd0);
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
            S_REQ: begin
               state <= S_WAIT_MEM;
               cnt   <= '0;
            end
            S_WAIT_MEM: begin
               // response takes priority over the timeout in the final cycle
               if (dmem_rvalid_i) begin
                  state     <= S_WRITE;
                  rd_o      <= lat_rd;
                  datawb_o  <= ld_data;
                  regwren_o <= lat_regwren && (lat_rd != 5'd0);
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  state <= S_IDLE;
                  err_o <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_ready;
   logic [4:0]  ex_rd;
   logic        ex_regwren;
   logic [1:0]  ex_wbsel;
   logic [31:0] ex_alu, ex_pc;
   logic [2:0]  ex_funct3;
   logic        dmem_req;
   logic [31:0] dmem_addr;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic [4:0]  rd_o;
   logic [31:0] datawb;
   logic        regwren;
   logic        pending;
   logic [4:0]  pending_rd;
   logic        err;

   int   n_chk  = 0;
   int   n_fail = 0;
   logic exp_err = 1'b0;

   always #5 clk = ~clk;

   writeback_unit #(.DWIDTH(32), .AWIDTH(32), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
      .ex_rd_i(ex_rd), .ex_regwren_i(ex_regwren), .ex_wbsel_i(ex_wbsel),
      .ex_alu_i(ex_alu), .ex_pc_i(ex_pc), .ex_funct3_i(ex_funct3),
      .dmem_req_o(dmem_req), .dmem_addr_o(dmem_addr),
      .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
      .rd_o(rd_o), .datawb_o(datawb), .regwren_o(regwren),
      .pending_o(pending), .pending_rd_o(pending_rd), .err_o(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic legal(input logic [2:0] f3, input logic [1:0] a);
      if (f3 == 3'd0 || f3 == 3'd4) return 1'b1;
      if (f3 == 3'd1 || f3 == 3'd5) return (a % 2) == 0;
      if (f3 == 3'd2) return a == 2'd0;
      return 1'b0;
   endfunction

   // arithmetic model of load extraction
   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] w);
      longint v;
      longint unsigned b;
      if (f3 == 3'd0 || f3 == 3'd4) begin
         b = (w >> (int'(lane) * 8)) & 32'hFF;
         v = longint'(b);
         if (f3 == 3'd0 && b >= 128) v = v - 256;
      end else if (f3 == 3'd1 || f3 == 3'd5) begin
         b = (w >> ((int'(lane) / 2) * 16)) & 32'hFFFF;
         v = longint'(b);
         if (f3 == 3'd1 && b >= 32768) v = v - 65536;
      end else begin
         v = longint'(w);
      end
      return v[31:0];
   endfunction

   task automatic do_reset();
      ex_valid    = 1'b0;
      dmem_rvalid = 1'b0;
      #2 rst = 1'b0;
      exp_err = 1'b0;
      #1;
      chk("rst_ready",   ex_ready,   1);
      chk("rst_req",     dmem_req,   0);
      chk("rst_addr",    dmem_addr,  0);
      chk("rst_rd",      rd_o,       0);
      chk("rst_data",    datawb,     0);
      chk("rst_wen",     regwren,    0);
      chk("rst_pending", pending,    0);
      chk("rst_prd",     pending_rd, 0);
      chk("rst_err",     err,        0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Drives one instruction from an empty unit and checks it through to IDLE.
   // delay >= TIMEOUT means the response never comes.
   task automatic do_instr(input logic [4:0] rd, input logic wen, input logic [1:0] wbsel,
                           input logic [31:0] alu, input logic [31:0] pc,
                           input logic [2:0] f3, input int delay, input logic [31:0] rdata);
      logic exp_wen;
      exp_wen = wen && (rd != 0);
      ex_valid = 1'b1; ex_rd = rd; ex_regwren = wen; ex_wbsel = wbsel;
      ex_alu = alu; ex_pc = pc; ex_funct3 = f3;
      step();
      ex_valid = 1'b0;
      if (wbsel != 2'd1) begin
         chk("wr_wen",   regwren,  exp_wen);
         chk("wr_rd",    rd_o,     rd);
         chk("wr_data",  datawb,   (wbsel == 2'd2) ? pc + 32'd4 : alu);
         chk("wr_ready", ex_ready, 1);
      end else if (!legal(f3, alu[1:0])) begin
         exp_err = 1'b1;
         chk("bad_req", dmem_req, 0);
         chk("bad_wen", regwren,  0);
         chk("bad_err", err,      exp_err);
      end else begin
         chk("ld_req",   dmem_req,  1);
         chk("ld_addr",  dmem_addr, alu & ~32'h3);
         chk("ld_ready", ex_ready,  0);
         dmem_rvalid = 1'b1;
         dmem_rdata  = ~rdata;
         step();
         dmem_rvalid = 1'b0;
         chk("ld_prd", pending_rd, wen ? rd : 5'd0);
         if (delay >= TIMEOUT) begin
            for (int i = 1; i < TIMEOUT; i++) begin
               step();
               chk("to_wait", {pending, regwren}, 2'b10);
            end
            step();
            exp_err = 1'b1;
            chk("to_pending", pending, 0);
            chk("to_wen",     regwren, 0);
            chk("to_err",     err,     exp_err);
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
            step();
            dmem_rvalid = 1'b0;
            chk("late_wen",     regwren, 0);
            chk("late_pending", pending, 0);
         end else begin
            for (int i = 0; i < delay; i++) step();
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
            step();
            dmem_rvalid = 1'b0;
            chk("ld_wen",  regwren, exp_wen);
            chk("ld_rd",   rd_o,    rd);
            chk("ld_data", datawb,  model_load(f3, alu[1:0], rdata));
         end
      end
      step();
      chk("end_wen",     regwren, 0);
      chk("end_pending", pending, 0);
      chk("end_err",     err,     exp_err);
   endtask

   initial begin
      rst = 1'b1; ex_valid = 1'b0; ex_rd = '0; ex_regwren = 1'b0; ex_wbsel = '0;
      ex_alu = '0; ex_pc = '0; ex_funct3 = '0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      do_reset();

      do_instr(5'd5, 1'b1, 2'd0, 32'h1234_5678, 32'h0,         3'd0, 0, 32'h0);
      do_instr(5'd1, 1'b1, 2'd2, 32'hDEAD_BEEF, 32'h0000_0100, 3'd0, 0, 32'h0);
      do_instr(5'd0, 1'b1, 2'd2, 32'hDEAD_BEEF, 32'h0000_0100, 3'd0, 0, 32'h0);
      do_instr(5'd7, 1'b1, 2'd3, 32'hCAFE_0001, 32'h0000_0200, 3'd0, 0, 32'h0);
      do_instr(5'd3, 1'b1, 2'd1, 32'h0000_1003, 32'h0, 3'b000, 1, 32'h80FF_FF7F);
      do_instr(5'd4, 1'b1, 2'd1, 32'h0000_1003, 32'h0, 3'b100, 1, 32'h80FF_FF7F);
      do_instr(5'd6, 1'b1, 2'd1, 32'h0000_2002, 32'h0, 3'b001, 0, 32'h8001_0000);
      do_instr(5'd8, 1'b1, 2'd1, 32'h0000_2000, 32'h0, 3'b101, TIMEOUT - 1, 32'h8001_9234);
      do_instr(5'd9, 1'b1, 2'd1, 32'h0000_2001, 32'h0, 3'b010, 0, 32'h0);

      do_reset();
      do_instr(5'd10, 1'b1, 2'd1, 32'h0000_3000, 32'h0, 3'b010, TIMEOUT, 32'h1111_2222);

      // back-to-back ALU ops
      ex_valid = 1'b1; ex_regwren = 1'b1; ex_wbsel = 2'd0;
      for (int k = 0; k < 3; k++) begin
         ex_rd  = 5'(11 + k);
         ex_alu = 32'hA000_0000 + 32'(k);
         step();
         chk("b2b_wen",   regwren,  1);
         chk("b2b_rd",    rd_o,     11 + k);
         chk("b2b_data",  datawb,   32'hA000_0000 + 32'(k));
         chk("b2b_ready", ex_ready, 1);
      end
      ex_valid = 1'b0;
      step();
      chk("b2b_end", regwren, 0);

      // reset while waiting for memory
      ex_valid = 1'b1; ex_rd = 5'd12; ex_regwren = 1'b1; ex_wbsel = 2'd1;
      ex_alu = 32'h0000_4000; ex_funct3 = 3'b010;
      step();
      ex_valid = 1'b0;
      step();
      chk("mid_pending", pending, 1);
      do_reset();
      dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
      step();
      dmem_rvalid = 1'b0;
      chk("mid_late_wen", regwren, 0);
      chk("mid_late_pend", pending, 0);

      for (int n = 0; n < 40; n++) begin
         logic [1:0] wb;
         wb = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) wb = 2'd1;
         do_instr(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), wb, $urandom,
                  $urandom, 3'($urandom_range(0, 7)), int'($urandom_range(0, TIMEOUT)),
                  $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final stage of the RV32I pipeline; sits directly upstream of the register file and drives its write port (rd, writeback data, write enable).
- Accepts one retiring instruction at a time from execute via valid/ready.
- Issues the data-memory read for loads, waits for the response with a timeout, then aligns and sign/zero-extends the data.
- Selects the writeback source (ALU, load, PC+4) and pulses a single register write.

Parameters:
DWIDTH, 32, data/writeback width
AWIDTH, 32, address width
TIMEOUT, 16, max WAIT_MEM cycles without dmem_rvalid_i before abort (>=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
ex_valid_i  in  1  execute presents an instruction
ex_ready_o  out  1  unit can accept this cycle
ex_rd_i  in  5  destination register
ex_regwren_i  in  1  instruction writes rd
ex_wbsel_i  in  2  0=ALU, 1=MEM, 2=PC+4, 3=reserved (treated as ALU)
ex_alu_i  in  DWIDTH  ALU result / load address
ex_pc_i  in  AWIDTH  instruction PC
ex_funct3_i  in  3  load size/sign
dmem_req_o  out  1  one-cycle read request
dmem_addr_o  out  AWIDTH  word-aligned read address
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  DWIDTH  read word
rd_o  out  5  register file rd
datawb_o  out  DWIDTH  register file write data
regwren_o  out  1  register file write enable
pending_o  out  1  instruction held in unit (hazard visibility)
pending_rd_o  out  5  rd of held instruction, 0 when none
err_o  out  1  sticky error: misaligned/illegal load or timeout

Behaviour:
- Reset (rst=0, async): state IDLE; counter 0; outputs ex_ready_o=1, dmem_req_o=0, dmem_addr_o=0, rd_o=0, datawb_o=0, regwren_o=0, pending_o=0, pending_rd_o=0, err_o=0.
- Reset mid-load aborts it; a late dmem_rvalid_i after reset is ignored.
- FSM states:
  - IDLE: ex_ready_o=1.
  - REQ: dmem_req_o=1, ex_ready_o=0.
  - WAIT_MEM: ex_ready_o=0.
  - WRITE: regwren_o may be 1, ex_ready_o=1.
- Acceptance is ex_valid_i && ex_ready_o, possible in IDLE or WRITE. All fields are latched on acceptance.
- Non-load instruction accepted in cycle N: state WRITE in N+1.
  - datawb_o = ALU result, or PC+4 (mod 2^AWIDTH, zero-extended to DWIDTH).
  - regwren_o = latched regwren && rd!=0.
- Load (wbsel=1) accepted in cycle N, legal and aligned: REQ in N+1 with dmem_addr_o = {alu[AWIDTH-1:2],2'b00}, then WAIT_MEM.
  - dmem_rvalid_i during REQ is ignored.
  - rvalid in WAIT_MEM at cycle M: WRITE at M+1. Earliest write is N+3.
- Load extraction, indexed by addr[1:0]:
  - 000 LB: byte at lane addr[1:0], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword at addr[1], sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW: full word.
- Illegal load (funct3 011/110/111), misaligned LH/LHU (addr[0]=1) or misaligned LW (addr[1:0]!=0): no request. Go to WRITE with regwren_o=0 and set err_o.
- Timeout: counter clears on entering WAIT_MEM and increments each WAIT_MEM cycle. Reaching TIMEOUT with no rvalid → IDLE, err_o=1, no write.
  - rvalid arriving in the same cycle the counter hits TIMEOUT wins: the write occurs, no error.
- WRITE lasts exactly one cycle. regwren_o is high only in WRITE. rd_o and datawb_o hold their last values otherwise.
  - With a new acceptance in WRITE, the next state follows the new instruction (back-to-back ALU ops give consecutive write pulses).
  - Otherwise the next state is IDLE.
- pending_o = state!=IDLE. pending_rd_o = latched rd when pending and regwren, else 0.
- dmem_rvalid_i in IDLE/WRITE is ignored.
- err_o clears only on reset.

Test Plan:
- ALU op rd=5, alu=0x1234_5678, accepted at N → cycle N+1: regwren_o=1, rd_o=5, datawb_o=0x12345678. Cycle N+2: regwren_o=0.
- JAL-style wbsel=2, pc=0x0000_0100, rd=1 → datawb_o=0x00000104. Repeat with rd=0 → regwren_o=0.
- LB at addr 0x1003, rdata=0x80FF_FF7F, rvalid 2 cycles after REQ → datawb_o=0xFFFFFF80. LBU at the same address → 0x00000080. dmem_addr_o=0x1000.
- LH at 0x2002, rdata=0x8001_0000 → 0xFFFF8001. LW at 0x2001 → no dmem_req_o, regwren_o=0, err_o=1.
- LW with rvalid never asserted, TIMEOUT=16 → 16 WAIT_MEM cycles, then IDLE, no write, err_o=1. Late rvalid ignored.
- Three back-to-back ALU ops with ex_valid_i held high → three consecutive regwren_o pulses, ex_ready_o stays 1. Assert rst=0 during WAIT_MEM → immediate IDLE, all outputs zero.
